// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad entry front end.
// Key codes, scanner state encoding and the (column, row) to code map.
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP     = 4'hB;
    localparam logic [3:0] KEY_CLR      = 4'hC;
    localparam logic [3:0] KEY_ENTER    = 4'hE;
    localparam logic [3:0] EMPTY_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } scan_state_e;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic logic [3:0] key_map(
        input logic [1:0] c,
        input logic [1:0] r
    );
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with slot divider and press/release debounce FSM.
// Emits one key_event per physical press; next-state event is exported.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_event_o,
    output logic [3:0] key_code_o,
    output logic       event_d_o,
    output logic [3:0] code_d_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE);

    scan_state_e   state_q, state_d;
    logic [SW-1:0] slot_q;
    logic [3:0]    col_q, col_d;
    logic [1:0]    cand_q, cand_d;
    logic [DW-1:0] stable_q, stable_d;
    logic          key_event_q;
    logic [3:0]    key_code_q;

    logic          tick;
    logic          low_any;
    logic [1:0]    low_idx;
    logic [1:0]    col_idx;
    logic          evt_d;
    logic [3:0]    code_d;

    assign tick    = (slot_q == SLOT_LAST);
    assign low_any = (row_i != 4'hF);

    // Slot divider: free-running, wraps after the last cycle of a slot
    always_ff @(posedge clk) begin
        if (rst)
            slot_q <= '0;
        else if (tick)
            slot_q <= '0;
        else
            slot_q <= slot_q + SW'(1);
    end

    // Lowest active row and the index of the driven column
    always_comb begin
        low_idx = 2'd0;
        if (!row_i[0])      low_idx = 2'd0;
        else if (!row_i[1]) low_idx = 2'd1;
        else if (!row_i[2]) low_idx = 2'd2;
        else if (!row_i[3]) low_idx = 2'd3;
        col_idx = 2'd0;
        if (!col_q[0])      col_idx = 2'd0;
        else if (!col_q[1]) col_idx = 2'd1;
        else if (!col_q[2]) col_idx = 2'd2;
        else if (!col_q[3]) col_idx = 2'd3;
    end

    // Debounce FSM next state; only acts on sample ticks
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        evt_d    = 1'b0;
        code_d   = key_code_q;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (low_any) begin
                        state_d  = CONFIRM;
                        cand_d   = low_idx;
                        stable_d = '0;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end
                CONFIRM: begin
                    if (low_any && low_idx == cand_q) begin
                        if (stable_q + DW'(1) == DB_LAST) begin
                            evt_d    = 1'b1;
                            code_d   = key_map(col_idx, cand_q);
                            state_d  = HELD;
                            stable_d = '0;
                        end else begin
                            stable_d = stable_q + DW'(1);
                        end
                    end else begin
                        state_d  = SCAN;
                        col_d    = {col_q[2:0], col_q[3]};
                        stable_d = '0;
                    end
                end
                HELD: begin
                    if (low_any) begin
                        stable_d = '0;
                    end else if (stable_q + DW'(1) == DB_LAST) begin
                        state_d  = SCAN;
                        col_d    = {col_q[2:0], col_q[3]};
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + DW'(1);
                    end
                end
                default: begin
                    state_d  = SCAN;
                    stable_d = '0;
                end
            endcase
        end
    end

    // Scanner state, column drive and event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 4'b1110;
            cand_q      <= 2'd0;
            stable_q    <= '0;
            key_event_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            key_event_q <= evt_d;
            key_code_q  <= code_d;
        end
    end

    assign col_o       = col_q;
    assign key_event_o = key_event_q;
    assign key_code_o  = key_code_q;
    assign event_d_o   = evt_d;
    assign code_d_o    = code_d;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry front end: BCD digit buffer with clear/backspace/enter.
// Completed entries are held valid until the consumer acknowledges.
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int DEBOUNCE   = 4,
    parameter int ENTER_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   row,
    output logic [3:0]                   col,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         value_valid,
    input  logic                         value_ack,
    output logic                         key_event,
    output logic [3:0]                   key_code
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int VW = 4 * DIGITS;
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [VW-1:0] value_q, value_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          evt_d;
    logic [3:0]    code_d;
    logic [VW-1:0] shl, shr;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .row_i       (row),
        .col_o       (col),
        .key_event_o (key_event),
        .key_code_o  (key_code),
        .event_d_o   (evt_d),
        .code_d_o    (code_d)
    );

    // Buffer next state; the event is applied on the edge that raises key_event
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        valid_d = valid_q;
        shl = value_q << 4;
        shl[3:0] = code_d;
        shr = value_q >> 4;
        shr[VW-1 -: 4] = EMPTY_NIBBLE;
        if (value_ack && valid_q) begin
            value_d = {DIGITS{EMPTY_NIBBLE}};
            count_d = '0;
            valid_d = 1'b0;
        end else if (evt_d) begin
            unique case (1'b1)
                (code_d <= 4'h9): begin
                    if (!valid_q && count_q < FULL) begin
                        value_d = shl;
                        count_d = count_q + CW'(1);
                        if (ENTER_MODE == 0 && count_q + CW'(1) == FULL)
                            valid_d = 1'b1;
                    end
                end
                (code_d == KEY_BKSP): begin
                    if (!valid_q && count_q != '0) begin
                        value_d = shr;
                        count_d = count_q - CW'(1);
                    end
                end
                (code_d == KEY_CLR): begin
                    value_d = {DIGITS{EMPTY_NIBBLE}};
                    count_d = '0;
                    valid_d = 1'b0;
                end
                (code_d == KEY_ENTER): begin
                    if (ENTER_MODE != 0 && !valid_q && count_q != '0)
                        valid_d = 1'b1;
                end
                default: begin
                    valid_d = valid_q;
                end
            endcase
        end
    end

    // Buffer, count and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= {DIGITS{EMPTY_NIBBLE}};
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign value       = value_q;
    assign count       = count_q;
    assign value_valid = valid_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench: a 4-digit auto-complete instance and a 6-digit
// enter-mode instance share one modelled key and the same reset.
module tb_keypad_entry_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row0, row1, col0, col1;
    logic [15:0] value0;
    logic [23:0] value1;
    logic [2:0]  count0, count1;
    logic        valid0, valid1, ack0, ack1;
    logic        ev0, ev1;
    logic [3:0]  code0, code1;

    logic        key_down;
    logic [1:0]  kc, kr;

    int total = 0;
    int bad = 0;
    int ev_cnt = 0;
    int e0;

    always #5 clk = ~clk;

    keypad_entry_buffer #(
        .DIGITS(4), .SCAN_DIV(4), .DEBOUNCE(2), .ENTER_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .row(row0), .col(col0),
        .value(value0), .count(count0), .value_valid(valid0),
        .value_ack(ack0), .key_event(ev0), .key_code(code0)
    );

    keypad_entry_buffer #(
        .DIGITS(6), .SCAN_DIV(4), .DEBOUNCE(2), .ENTER_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .row(row1), .col(col1),
        .value(value1), .count(count1), .value_valid(valid1),
        .value_ack(ack1), .key_event(ev1), .key_code(code1)
    );

    always_comb begin
        row0 = (key_down && !col0[kc]) ? ~(4'b0001 << kr) : 4'hF;
        row1 = (key_down && !col1[kc]) ? ~(4'b0001 << kr) : 4'hF;
    end

    always @(posedge clk) if (ev0) ev_cnt <= ev_cnt + 1;

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input logic [3:0] k);
        logic [3:0] p;
        case (k)
            4'h1: p = 4'h0;  4'h2: p = 4'h4;  4'h3: p = 4'h8;
            4'hA: p = 4'hC;  4'h4: p = 4'h1;  4'h5: p = 4'h5;
            4'h6: p = 4'h9;  4'hB: p = 4'hD;  4'h7: p = 4'h2;
            4'h8: p = 4'h6;  4'h9: p = 4'hA;  4'hC: p = 4'hE;
            4'h0: p = 4'h3;  4'hF: p = 4'h7;  4'hE: p = 4'hB;
            default: p = 4'hF;
        endcase
        {kc, kr} = p;
    endtask

    task automatic do_reset();
        key_down = 1'b0;
        ack0 = 1'b0;
        ack1 = 1'b0;
        rst = 1'b1;
        tick1();
        tick1();
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        logic got;
        got = 1'b0;
        set_key(k);
        key_down = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick1();
            if (ev0) begin
                got = 1'b1;
                break;
            end
        end
        check("press_evt", 32'(got), 32'd1);
    endtask

    task automatic release_key();
        key_down = 1'b0;
        repeat (40) tick1();
    endtask

    task automatic tap(input logic [3:0] k);
        press(k);
        release_key();
    endtask

    // Leaves the bench just after the edge that moved col0 onto the key's column
    task automatic align(input logic [3:0] k);
        logic [3:0] tgt;
        set_key(k);
        tgt = ~(4'b0001 << kc);
        for (int i = 0; i < 40 && col0 == tgt; i++) tick1();
        for (int i = 0; i < 40 && col0 != tgt; i++) tick1();
        check("align_col", 32'(col0), 32'(tgt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        key_down = 1'b0;
        kc = 2'd0;
        kr = 2'd0;
        do_reset();

        check("rst_col", 32'(col0), 32'hE);
        check("rst_value0", 32'(value0), 32'hFFFF);
        check("rst_value1", 32'(value1), 32'hFFFFFF);
        check("rst_count", 32'(count0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_event", 32'(ev0), 32'd0);
        check("rst_code", 32'(code0), 32'd0);

        tap(4'h1);
        check("d1_value", 32'(value0), 32'hFFF1);
        tap(4'h2);
        tap(4'h3);
        check("d3_value", 32'(value0), 32'hF123);
        check("d3_count", 32'(count0), 32'd3);
        check("d3_valid", 32'(valid0), 32'd0);
        press(4'h4);
        check("d4_value", 32'(value0), 32'h1234);
        check("d4_count", 32'(count0), 32'd4);
        check("d4_valid", 32'(valid0), 32'd1);
        release_key();
        tap(4'h5);
        check("d5_value", 32'(value0), 32'h1234);
        check("d5_count", 32'(count0), 32'd4);
        check("d5_code", 32'(code0), 32'h5);
        check("m1_value", 32'(value1), 32'hF12345);
        check("m1_valid", 32'(valid1), 32'd0);
        ack1 = 1'b1;
        tick1();
        ack1 = 1'b0;
        check("m1_ack_idle", 32'(value1), 32'hF12345);
        ack0 = 1'b1;
        tick1();
        ack0 = 1'b0;
        check("ack_valid", 32'(valid0), 32'd0);
        check("ack_value", 32'(value0), 32'hFFFF);
        check("ack_count", 32'(count0), 32'd0);

        e0 = ev_cnt;
        press(4'h5);
        repeat (200) tick1();
        release_key();
        check("hold_events", 32'(ev_cnt - e0), 32'd1);
        check("hold_code", 32'(code0), 32'h5);

        e0 = ev_cnt;
        align(4'h8);
        key_down = 1'b1;
        repeat (4) tick1();
        key_down = 1'b0;
        repeat (4) tick1();
        tap(4'h8);
        check("bounce_events", 32'(ev_cnt - e0), 32'd1);

        do_reset();
        tap(4'h7);
        tap(4'h8);
        tap(4'hB);
        check("bksp_value", 32'(value0), 32'hFFF7);
        check("bksp_count", 32'(count0), 32'd1);
        tap(4'hB);
        tap(4'hB);
        check("bksp0_value", 32'(value0), 32'hFFFF);
        check("bksp0_count", 32'(count0), 32'd0);

        do_reset();
        tap(4'h9);
        tap(4'h0);
        check("ent_pre_valid", 32'(valid1), 32'd0);
        tap(4'hE);
        check("ent_valid", 32'(valid1), 32'd1);
        check("ent_value", 32'(value1), 32'hFFFF90);
        check("ent_count", 32'(count1), 32'd2);
        check("ent_mode0", 32'(valid0), 32'd0);
        check("ent_mode0_v", 32'(value0), 32'hFF90);
        tap(4'hC);
        check("clr_valid", 32'(valid1), 32'd0);
        check("clr_value", 32'(value1), 32'hFFFFFF);
        check("clr_count", 32'(count1), 32'd0);
        tap(4'hE);
        check("ent_empty", 32'(valid1), 32'd0);

        do_reset();
        tap(4'h1);
        tap(4'h2);
        tap(4'h3);
        tap(4'h4);
        check("sim_pre_valid", 32'(valid0), 32'd1);
        align(4'h6);
        key_down = 1'b1;
        repeat (11) tick1();
        check("sim_no_early", 32'(ev0), 32'd0);
        ack0 = 1'b1;
        tick1();
        ack0 = 1'b0;
        check("sim_event", 32'(ev0), 32'd1);
        check("sim_code", 32'(code0), 32'h6);
        check("sim_valid", 32'(valid0), 32'd0);
        check("sim_value", 32'(value0), 32'hFFFF);
        check("sim_count", 32'(count0), 32'd0);
        release_key();

        align(4'h9);
        key_down = 1'b1;
        repeat (6) tick1();
        check("cf_col", 32'(col0), 32'hB);
        e0 = ev_cnt;
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        check("cf_rst_col", 32'(col0), 32'hE);
        check("cf_rst_event", 32'(ev0), 32'd0);
        check("cf_rst_code", 32'(code0), 32'h0);
        check("cf_rst_value", 32'(value0), 32'hFFFF);
        check("cf_rst_count", 32'(count0), 32'd0);
        check("cf_rst_valid", 32'(valid0), 32'd0);
        repeat (12) tick1();
        check("cf_no_event", 32'(ev_cnt - e0), 32'd0);
        release_key();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Parametrised 4x4 matrix-keypad front end: scans the keypad columns, debounces presses, and collects up to DIGITS decimal digits into a packed BCD buffer. Supports clear and backspace keys and an optional explicit-enter mode. Presents the completed entry to the game controller through a valid/ack handshake. Replaces the fixed four-digit, edge-clocked decoder.

## Interface
- DIGITS, 4: buffer depth in BCD digits (1..8).
- SCAN_DIV, 100000: clk cycles per column slot. A sample tick fires on the last cycle of each slot.
- DEBOUNCE, 4: consecutive stable sample ticks required for press and release (>=1).
- ENTER_MODE, 0: 0 = entry completes automatically at DIGITS digits; 1 = entry completes on the enter key.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  4  keypad rows, active-low, already synchronised
- col  out  4  keypad column drive, active-low one-hot
- value  out  4*DIGITS  BCD digits; newest digit in [3:0]; empty slots 4'hF
- count  out  $clog2(DIGITS+1)  digits currently held
- value_valid  out  1  entry complete, held until ack
- value_ack  in  1  consumer accepts entry
- key_event  out  1  one-cycle pulse per debounced press
- key_code  out  4  code of the last pressed key

## Operation
- Key map (col, row → code): row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D.
- Digit keys: 0–9. Backspace: B. Clear: C. Enter: E. Keys A, D, F produce key_event only and have no buffer effect.
- Scanner FSM states:
  - SCAN: col rotates 1110→1101→1011→0111→1110, one slot each. At a tick, any low row → CONFIRM with col frozen and candidate = lowest low row index.
  - CONFIRM: at each tick, the same row low increments stable; a different or no row → SCAN with the column advanced. stable==DEBOUNCE → key_event=1, key_code updated, go to HELD.
  - HELD: col frozen. Counts consecutive ticks with row==4'hF and resets the count on any low row. At DEBOUNCE → SCAN with the column advanced.
  - Result: exactly one event per physical press. Other keys are ignored while in HELD.
- Buffer action on key_event:
  - Digit, valid=0, count<DIGITS: value ← {value[4*DIGITS-5:0], digit}, count+1.
  - Digit when count==DIGITS or valid=1: ignored.
  - Backspace, valid=0, count>0: value ← {4'hF, value[4*DIGITS-1:4]}, count−1. Ignored when count==0.
  - Clear: value all F, count 0, valid 0. Acts even when valid=1.
  - Enter (ENTER_MODE=1, valid=0, count>0): valid ← 1. Ignored when count==0 and in ENTER_MODE=0.
  - ENTER_MODE=0: valid ← 1 on the same edge that count reaches DIGITS.
- Ack: value_ack while valid=1 → valid 0, value all F, count 0. Ack while valid=0 is ignored.
- Simultaneous ack and key_event: ack is applied and the key is dropped from the buffer. key_event and key_code still update.

## Timing
- Reset values: col=4'b1110, value all 4'hF, count=0, value_valid=0, key_event=0, key_code=0, FSM=SCAN, slot counter=0, stable=0.
- Reset mid-press: the FSM returns to SCAN and the held key is re-detected only after a full debounce.
- Press latency: key_event rises DEBOUNCE ticks after the first detecting tick, i.e. DEBOUNCE*SCAN_DIV cycles plus one registered cycle.
- value, count and valid update on the same edge that raises key_event, so all three are visible together with the pulse.
- Ack: valid falls on the edge after value_ack is sampled high.
- Slot counter width: $clog2(SCAN_DIV). It wraps to 0 after SCAN_DIV−1.
- All outputs are registered.

## Structure
- Package keypad_pkg holds:
  - key code constants (KEY_BKSP=4'hB, KEY_CLR=4'hC, KEY_ENTER=4'hE, EMPTY_NIBBLE=4'hF);
  - the scanner state enum {SCAN, CONFIRM, HELD};
  - the key map function.
- Sub-module keypad_scanner contains the column drive, tick divider, debounce FSM, key_event and key_code. The top level owns the buffer, count and handshake.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=2.
- ENTER_MODE=0, press 1,2,3,4 → value=16'h1234, count=4, valid=1 on the 4th key_event. A 5th digit is ignored. Ack → value=16'hFFFF, valid=0.
- Key 5 held 50 ticks → exactly one key_event with key_code=5.
- Bounce: row low for 1 tick, high, then low 2 ticks → one event only.
- Press 7,8, B → value=16'hFFF7, count=1. B at count 0 → no change.
- ENTER_MODE=1, DIGITS=6, press 9,0 then E → valid=1, value=24'hFFFF90. Press C → valid=0, value all F.
- value_ack on the same cycle as a digit key_event → buffer cleared, digit absent, count=0.
- rst asserted in CONFIRM → all reset values next cycle, no key_event.
